// File: rtl/i2c_slave_if.sv
// Pad and byte-stream signals between the I2C target and its pads/bridge.
// The slave modport is the target's view; master is the pads/bridge view.
interface i2c_slave_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] write_data;
  logic       write_valid;
  logic       write_ready;
  logic [7:0] read_data;
  logic       read_valid;
  logic       read_ready;
  logic       i2c_read;
  logic       i2c_write;

  modport slave (
    input  scl_in, sda_in, write_ready, read_data, read_valid,
    output sda_oe, write_data, write_valid, read_ready, i2c_read, i2c_write
  );

  modport master (
    output scl_in, sda_in, write_ready, read_data, read_valid,
    input  sda_oe, write_data, write_valid, read_ready, i2c_read, i2c_write
  );
endinterface

// File: rtl/i2c_slave.sv
// Byte-level I2C target: synchronises and filters SCL/SDA, decodes START/STOP,
// matches the address and moves bytes over valid/ready and ready-pulse interfaces.
module i2c_slave #(
  parameter logic [6:0]  ADDRESS    = 7'h42,
  parameter int unsigned FILTER_LEN = 3
) (
  input logic        clk,
  input logic        rst,
  i2c_slave_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StWriteByte, StWriteAck, StReadByte, StReadAck
  } state_e;

  localparam logic [3:0] FiltMax = 4'(FILTER_LEN - 1);

  // Index 1 = SCL, index 0 = SDA.
  logic [1:0] raw;
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] filt_q, filt_d, prev_q;
  logic [3:0] cnt_q [2];
  logic [3:0] cnt_d [2];

  assign raw = {bus.scl_in, bus.sda_in};

  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = 4'd0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == FiltMax) filt_d[i] = sync2_q[i];
        else                     cnt_d[i] = cnt_q[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      filt_q  <= 2'b11;
      prev_q  <= 2'b11;
      for (int i = 0; i < 2; i++) cnt_q[i] <= 4'd0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      prev_q  <= filt_q;
      for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
  assign scl_f     = filt_q[1];
  assign sda_f     = filt_q[0];
  assign scl_rise  = filt_q[1] & ~prev_q[1];
  assign scl_fall  = ~filt_q[1] & prev_q[1];
  assign start_det = ~filt_q[0] & prev_q[0] & scl_f;
  assign stop_det  = filt_q[0] & ~prev_q[0] & scl_f;

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_q, tx_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] wdata_q, wdata_d;
  logic       wvalid_q, wvalid_d;
  logic       rready_q, rready_d;
  logic       i2c_read_q, i2c_read_d;
  logic       i2c_write_q, i2c_write_d;
  logic [7:0] next_byte;

  assign next_byte = bus.read_valid ? bus.read_data : 8'hFF;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    wdata_d     = wdata_q;
    wvalid_d    = wvalid_q;
    rready_d    = 1'b0;
    i2c_read_d  = 1'b0;
    i2c_write_d = 1'b0;

    if (wvalid_q && bus.write_ready) wvalid_d = 1'b0;

    if (start_det) begin
      state_d   = StAddr;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: sda_oe_d = 1'b0;
        StAddr: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[6:0], sda_f};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (shift_q[7:1] == ADDRESS) begin
              sda_oe_d    = 1'b1;
              rw_d        = shift_q[0];
              i2c_read_d  = shift_q[0];
              i2c_write_d = ~shift_q[0];
              state_d     = StAddrAck;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            if (rw_q) begin
              // Drive bit 7 now; tx keeps the remaining bits MSB-aligned.
              tx_d      = {next_byte[6:0], 1'b1};
              sda_oe_d  = ~next_byte[7];
              bit_cnt_d = 4'd1;
              rready_d  = 1'b1;
              state_d   = StReadByte;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = StWriteByte;
            end
          end
        end
        StWriteByte: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[6:0], sda_f};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            state_d = StWriteAck;
            if (!wvalid_q) begin
              wdata_d  = shift_q;
              wvalid_d = 1'b1;
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
            end
          end
        end
        StWriteAck: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = StWriteByte;
          end
        end
        StReadByte: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = StReadAck;
            end else begin
              sda_oe_d  = ~tx_q[7];
              tx_d      = {tx_q[6:0], 1'b1};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        StReadAck: begin
          if (scl_rise && sda_f) begin
            state_d = StIdle;
          end else if (scl_fall) begin
            tx_d      = {next_byte[6:0], 1'b1};
            sda_oe_d  = ~next_byte[7];
            bit_cnt_d = 4'd1;
            rready_d  = 1'b1;
            state_d   = StReadByte;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      tx_q        <= 8'hFF;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      wdata_q     <= 8'h00;
      wvalid_q    <= 1'b0;
      rready_q    <= 1'b0;
      i2c_read_q  <= 1'b0;
      i2c_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      wdata_q     <= wdata_d;
      wvalid_q    <= wvalid_d;
      rready_q    <= rready_d;
      i2c_read_q  <= i2c_read_d;
      i2c_write_q <= i2c_write_d;
    end
  end

  assign bus.sda_oe      = sda_oe_q;
  assign bus.write_data  = wdata_q;
  assign bus.write_valid = wvalid_q;
  assign bus.read_ready  = rready_q;
  assign bus.i2c_read    = i2c_read_q;
  assign bus.i2c_write   = i2c_write_q;

endmodule
